// File: rtl/mem_copy.sv
// Word-by-word memory copy engine driving a single-port data memory.
// Each word takes one READ cycle and one WRITE cycle, in ascending address order.
module mem_copy #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] src_ptr, dst_ptr, data;
  logic [LEN_W-1:0] count;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len != '0) ? READ : DONE;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = (count == LEN_W'(1)) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operands are captured once at acceptance, so later input changes are ignored.
  // NOTE: sequential state uses non-blocking '<=', and every register (data included) is cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      data    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_ptr <= src;
          dst_ptr <= dst;
          count   <= len;
        end
        READ:  data <= mem_rd;
        WRITE: begin
          // Pointers wrap modulo 2^WIDTH by plain truncating addition.
          src_ptr <= src_ptr + WIDTH'(1);
          dst_ptr <= dst_ptr + WIDTH'(1);
          count   <= count - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (state)
      READ:  mem_addr = src_ptr;
      WRITE: begin
        mem_addr = dst_ptr;
        mem_wd   = data;
        mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy.sv
// Self-checking bench for mem_copy: table-driven copies, randomized copies against a
// word-array reference model, and hand-written reset / busy-start / back-to-back sequences.
module tb_mem_copy;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src, dst;
  logic [7:0]  len;
  logic        busy, done, mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  mem_copy dut (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Behavioural memory: 256 words aliased on the low address byte; write addresses
  // are logged at full width so high-bit errors are still visible.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] wr_addrs [$];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_addr = '0;
  logic [31:0] tb_wd = '0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd;
      wr_addrs.push_back(mem_addr);
    end else if (tb_we) begin
      mem[tb_addr] <= tb_wd;
    end
  end

  // Read data is refreshed mid-cycle, so it is valid at the edge ending the cycle.
  always @(negedge clk) mem_rd <= mem[mem_addr[7:0]];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] v);
    tb_we = 1'b1; tb_addr = a; tb_wd = v; ref_mem[a] = v;
    step();
    tb_we = 1'b0;
  endtask

  // Reference model: a forward word-by-word copy, overlap handled naturally.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa, da;
      sa = s + 32'(i);
      da = d + 32'(i);
      ref_mem[da[7:0]] = ref_mem[sa[7:0]];
    end
  endtask

  task automatic compare_mem(input string name);
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
    check({name, " mem_errs"}, 64'(errs), 64'd0);
  endtask

  task automatic check_wr_addrs(input string name, input logic [31:0] d, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < wr_addrs.size(); i++)
      if (i >= n || wr_addrs[i] !== d + 32'(i)) errs++;
    check({name, " wr_addr_errs"}, 64'(errs), 64'd0);
  endtask

  // Starts a copy from an idle DUT (called #1 after an edge) and waits, bounded, for done.
  task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] n, input int exp_writes, input int exp_done);
    int done_at, busy_low;
    wr_addrs.delete();
    done_at = -1; busy_low = 0;
    start = 1'b1; src = s; dst = d; len = n;
    step();
    start = 1'b0; src = $urandom; dst = $urandom; len = 8'($urandom);
    for (int c = 1; c <= 600; c++) begin
      if (!busy) busy_low++;
      if (done) begin done_at = c; break; end
      step();
    end
    step();
    model_copy(s, d, int'(n));
    check({name, " done_cycle"}, 64'(done_at), 64'(exp_done));
    check({name, " writes"}, 64'(wr_addrs.size()), 64'(exp_writes));
    check({name, " busy_low_cycles"}, 64'(busy_low), 64'd0);
    check({name, " idle_after"}, {62'd0, busy, done}, 64'd0);
    check_wr_addrs(name, d, int'(n));
    compare_mem(name);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    int          exp_writes;
    int          exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen, done_cnt, first_done, last_done, spacing_bad;

    vecs[0] = '{32'h10,        32'h40,        8'd4,   4,   9};
    vecs[1] = '{32'h33,        32'h34,        8'd0,   0,   1};
    vecs[2] = '{32'hFFFF_FFFF, 32'h20,        8'd2,   2,   5};
    vecs[3] = '{32'h5,         32'h6,         8'd2,   2,   5};
    vecs[4] = '{32'h1000_0000, 32'h2000_0001, 8'd255, 255, 511};

    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    step(); step();
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wd", 64'(mem_wd), 64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; len = 8'd3; src = 32'h1; dst = 32'h2;
    step();
    reset = 1'b0; start = 1'b0;
    check("rst_prio busy", 64'(busy), 64'd0);
    step();
    check("rst_prio still_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    wr_addrs.delete();

    // Table-driven copies
    for (int v = 0; v < 5; v++) begin
      if (v == 0) for (int k = 0; k < 4; k++) poke(8'h10 + 8'(k), 32'hA0 + 32'(k));
      if (v == 3) begin poke(8'd5, 32'd1); poke(8'd6, 32'd2); poke(8'd7, 32'd3); end
      run_copy($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].len,
               vecs[v].exp_writes, vecs[v].exp_done);
      if (v == 0) for (int k = 0; k < 4; k++)
        check($sformatf("vec0 word%0d", k), 64'(mem[8'h40 + 8'(k)]), 64'(32'hA0 + 32'(k)));
      if (v == 3) for (int k = 5; k <= 7; k++)
        check($sformatf("overlap word%0d", k), 64'(mem[k]), 64'd1);
    end

    // Randomized copies against the reference model
    for (int k = 0; k < 20; k++) begin
      logic [31:0] s, d;
      logic [7:0]  n;
      s = 32'($urandom_range(0, 63));
      d = 32'($urandom_range(0, 63));
      n = 8'($urandom_range(0, 15));
      run_copy($sformatf("rand%0d", k), s, d, n, int'(n), 2 * int'(n) + 1);
    end

    // Reset in the cycle after the second write aborts the copy.
    wr_addrs.delete();
    done_seen = 0;
    start = 1'b1; src = 32'h10; dst = 32'h40; len = 8'd4;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (done) done_seen++;
      step();
    end
    if (done) done_seen++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_copy(32'h10, 32'h40, 2);
    check("abort writes", 64'(wr_addrs.size()), 64'd2);
    check("abort no_done", 64'(done_seen), 64'd0);
    check("abort outputs", {29'd0, busy, done, mem_we, mem_addr, mem_wd[1:0]}, 64'd0);
    check("abort mem_wd", 64'(mem_wd), 64'd0);
    compare_mem("abort");
    // New start on the very first cycle after reset.
    start = 1'b1; src = 32'h8; dst = 32'h9; len = 8'd1;
    step();
    start = 1'b0;
    check("post_rst busy", 64'(busy), 64'd1);
    for (int c = 0; c < 10 && busy; c++) step();
    model_copy(32'h8, 32'h9, 1);
    compare_mem("post_rst");

    // Start pulse during a busy copy is ignored and not queued.
    wr_addrs.delete();
    start = 1'b1; src = 32'h30; dst = 32'h50; len = 8'd3;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; src = 32'h80; dst = 32'h90; len = 8'd7;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) step();
    model_copy(32'h30, 32'h50, 3);
    check("busy_start writes", 64'(wr_addrs.size()), 64'd3);
    check("busy_start idle", 64'(busy), 64'd0);
    compare_mem("busy_start");

    // Start held high relaunches every 2N+2 cycles.
    wr_addrs.delete();
    done_cnt = 0; first_done = -1; last_done = -1; spacing_bad = 0;
    start = 1'b1; src = 32'h60; dst = 32'h70; len = 8'd2;
    step();
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        else if (c - last_done != 6) spacing_bad++;
        last_done = c;
        if (done_cnt == 3) begin start = 1'b0; end
      end
      step();
    end
    start = 1'b0;
    model_copy(32'h60, 32'h70, 2);
    check("held_start first_done", 64'(first_done), 64'd5);
    check("held_start done_count", 64'(done_cnt), 64'd3);
    check("held_start spacing", 64'(spacing_bad), 64'd0);
    check("held_start writes", 64'(wr_addrs.size()), 64'd6);
    compare_mem("held_start");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_copy.md
MEM_COPY -- requirements
Module: mem_copy

Interface
REQ-001 Parameter WIDTH, default 32: data and address width in bits.
REQ-002 Parameter LEN_W, default 8: width of the word-count input.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to begin a copy; sampled only in IDLE.
REQ-006 src  input  WIDTH  first source word address.
REQ-007 dst  input  WIDTH  first destination word address.
REQ-008 len  input  LEN_W  number of words to copy (0 is legal).
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is left.
REQ-010 done  output  1  one-cycle pulse when a copy completes.
REQ-011 mem_we  output  1  write enable to the data memory.
REQ-012 mem_addr  output  WIDTH  word address to the data memory.
REQ-013 mem_wd  output  WIDTH  write data to the data memory.
REQ-014 mem_rd  input  WIDTH  read data from the data memory.

Function
REQ-015 The block shall drive the data memory's single port, which uses word addressing (address +1 = next word) and has these timing properties:
- Write takes effect on the rising edge while mem_we=1.
- Read data for the address presented during a cycle is valid on mem_rd at the rising edge that ends that cycle.
REQ-016 The block shall be a state machine with the following states and transitions:
- IDLE: start=1 & len!=0 -> READ. start=1 & len=0 -> DONE. Otherwise stay in IDLE.
- READ -> WRITE.
- WRITE: remaining count after this write = 0 -> DONE. Otherwise -> READ.
- DONE -> IDLE.
REQ-017 On start acceptance the block shall latch src, dst and len into internal src_ptr, dst_ptr and count registers; input changes after acceptance shall have no effect on the copy.
REQ-018 In READ the block shall drive mem_addr=src_ptr and mem_we=0, and shall capture mem_rd into the data register at the rising edge that ends the cycle.
REQ-019 In WRITE the block shall drive mem_addr=dst_ptr, mem_wd=data register and mem_we=1 for exactly one cycle.
REQ-020 At the end of each WRITE the block shall increment src_ptr and dst_ptr by 1 and decrement count by 1.
REQ-021 A copy of N words shall take exactly 2N cycles in READ/WRITE, with one write per word in ascending address order.
REQ-022 Pointer arithmetic shall be modulo 2^WIDTH; an address of all ones wraps to 0 with no error.
REQ-023 Overlapping regions shall be copied strictly in forward order; if dst>src and the regions overlap, already-written words are re-read. This behaviour is defined, not an error.
REQ-024 mem_we shall be 0 in every state other than WRITE.
REQ-025 mem_addr and mem_wd shall be 0 in IDLE and DONE.
REQ-026 done shall be 1 only in DONE; busy shall be 1 in READ, WRITE and DONE.
REQ-027 start asserted while busy=1 shall be ignored and shall not be queued.
REQ-028 start held high continuously shall launch a new copy on each pass through IDLE, i.e. every 2N+2 cycles.
REQ-029 len = 2^LEN_W-1 shall copy exactly that many words, with no counter overflow.

Reset
REQ-030 While reset=1 at a rising edge, the block shall enter IDLE and clear src_ptr, dst_ptr, count and the data register to 0.
REQ-031 After that edge, busy=0, done=0, mem_we=0, mem_addr=0 and mem_wd=0.
REQ-032 Reset shall take priority over start in the same cycle.
REQ-033 Reset asserted mid-copy shall abort the copy:
- Memory writes completed before the reset edge remain.
- No further write occurs.
- No done pulse is produced.
REQ-034 After reset deasserts, the block shall accept start on the first cycle.

Verification
REQ-035 Memory words 0x10..0x13 = A0,A1,A2,A3. Start with src=0x10, dst=0x40, len=4 -> words 0x40..0x43 = A0..A3; done pulses 9 cycles after the start edge; exactly 4 cycles have mem_we=1.
REQ-036 Start with len=0 -> done pulses on the cycle after acceptance; mem_we stays 0 throughout.
REQ-037 Start with src=0xFFFFFFFF, dst=0x20, len=2 -> word 0x20 = mem[0xFFFFFFFF] and word 0x21 = mem[0x0].
REQ-038 Memory words 5..7 = 1,2,3. Start with src=5, dst=6, len=2 -> words 5..7 = 1,1,1 (forward propagation).
REQ-039 Start with len=4, then assert reset in the cycle after the 2nd write -> exactly 2 writes occur, no done pulse, all outputs 0 after reset, and a new start is accepted immediately afterwards.
REQ-040 A second start pulse issued during a busy copy -> ignored; the total write count equals the first len.
